mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  launch a multi-cycle op (MULT/MULTU/DIV/DIVU) in md_op.
REQ-006 SHALL have port md_op  input  3  op code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package encodings).
REQ-007 SHALL have port wr_en  input  1  perform the MTHI/MTLO write selected by md_op.
REQ-008 SHALL have port A  input  32  operand rs (or MTHI/MTLO data).
REQ-009 SHALL have port B  input  32  operand rt.
REQ-010 SHALL have port busy  output  1  op in flight; the hazard unit stalls MD instructions on start|busy.
REQ-011 SHALL have port HI  output  32  architectural HI register.
REQ-012 SHALL have port LO  output  32  architectural LO register.

Function
REQ-013 SHALL implement FSM states IDLE, MUL_RUN, DIV_RUN; busy = (state != IDLE), registered.
REQ-014 In IDLE, start=1 with a mult op at an edge SHALL latch A/B/op, load counter with MUL_LAT, and enter MUL_RUN; div ops load DIV_LAT and enter DIV_RUN.
REQ-015 Each edge in a RUN state SHALL decrement counter; the edge where counter==1 SHALL write HI/LO and return to IDLE, so busy is high exactly LAT cycles.
REQ-016 MULT SHALL write the signed 64-bit product, MULTU the unsigned product, with {HI,LO} = product.
REQ-017 DIV/DIVU SHALL write LO = quotient and HI = remainder, signed truncating toward zero for DIV and unsigned for DIVU.
REQ-018 Divisor B==0 SHALL run the full DIV_LAT and leave HI/LO unchanged.
REQ-019 Results SHALL derive only from operands latched at start, not from A/B during the run.
REQ-020 In IDLE, wr_en=1 with MTHI SHALL write HI=A at that edge, and with MTLO SHALL write LO=A, with no busy.
REQ-021 start or wr_en while busy SHALL be ignored, leaving state, counter and HI/LO unaffected.
REQ-022 start and wr_en both high in IDLE SHALL give start priority, and the wr_en SHALL be dropped.
REQ-023 start with a non-mult/div md_op SHALL be ignored.
REQ-024 HI/LO SHALL change only at the completion edge (REQ-015), an MTHI/MTLO edge, or reset.

Reset
REQ-025 reset SHALL asynchronously force state=IDLE, counter=0, busy=0, HI=0, LO=0, including mid-operation, with no result written.
REQ-026 The first start after reset release SHALL behave as REQ-014.

Structure
REQ-027 md_op encodings and the state enumeration SHALL reside in shared package mdu_pkg, with latency defaults as package constants.
REQ-028 Arithmetic SHALL be in one combinational sub-module mdu_calc (latched op/A/B -> 64-bit result, div0 flag); mdu_ctrl SHALL hold only FSM, counter, operand latches and HI/LO.

Verification
REQ-029 MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-031 DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged, busy still 10 cycles.
REQ-032 MTLO A=0x12345678 in IDLE -> LO=0x12345678 next edge and busy stays 0; MTHI during a DIV run -> HI unaffected.
REQ-033 start MULT, change A/B every cycle, and pulse start again at cycle 2 -> result uses the original operands, and the second start is ignored.
REQ-034 Assert reset at cycle 3 of DIV with HI/LO preloaded -> busy=0 and HI=LO=0 immediately, with no later write.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2
   } state_e;

   localparam int MUL_LAT_DEF = 5;
   localparam int DIV_LAT_DEF = 10;

   function automatic logic is_mul(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: latched op/operands in,
// {HI,LO} result and divide-by-zero flag out.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [63:0] res_o,
   output logic        div0_o
);

   logic signed [63:0] sa, sb;
   logic signed [31:0] sq, sr;
   logic [31:0]        uq, ur, bsafe;
   logic               b_zero, s_ovf;

   assign sa     = {{32{a_i[31]}}, a_i};
   assign sb     = {{32{b_i[31]}}, b_i};
   assign b_zero = (b_i == 32'd0);
   // INT_MIN / -1 is special-cased so the divider never sees the overflow case
   assign s_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
   assign bsafe  = (b_zero || s_ovf) ? 32'd1 : b_i;

   always_comb begin
      sq = $signed(a_i) / $signed(bsafe);
      sr = $signed(a_i) % $signed(bsafe);
      if (s_ovf) begin
         sq = 32'sh8000_0000;
         sr = 32'sd0;
      end
      uq = a_i / bsafe;
      ur = a_i % bsafe;
   end

   always_comb begin
      res_o  = 64'd0;
      div0_o = 1'b0;
      case (op_i)
         OP_MULT:  res_o = sa * sb;
         OP_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
         OP_DIV: begin
            res_o  = {sr, sq};
            div0_o = b_zero;
         end
         OP_DIVU: begin
            res_o  = {ur, uq};
            div0_o = b_zero;
         end
         default: res_o = 64'd0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide control: FSM, latency counter, operand latches and the
// architectural HI/LO registers.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int DIV_LAT = DIV_LAT_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic        wr_en,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic [31:0]        a_q, a_d, b_q, b_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic               busy_q, busy_d;
   logic [63:0]        res;
   logic               div0;

   mdu_calc u_calc (
      .op_i   (op_q),
      .a_i    (a_q),
      .b_i    (b_q),
      .res_o  (res),
      .div0_o (div0)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (start && is_mul(md_op)) begin
               state_d = MUL_RUN;
               cnt_d   = CNT_W'(MUL_LAT);
               op_d    = md_op;
               a_d     = A;
               b_d     = B;
            end else if (start && is_div(md_op)) begin
               state_d = DIV_RUN;
               cnt_d   = CNT_W'(DIV_LAT);
               op_d    = md_op;
               a_d     = A;
               b_d     = B;
            end else if (wr_en && !start) begin
               // any start, even an unrecognised one, swallows a concurrent write
               if (md_op == OP_MTHI) hi_d = A;
               if (md_op == OP_MTLO) lo_d = A;
            end
         end
         MUL_RUN, DIV_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               if (!div0) {hi_d, lo_d} = res;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table plus multi-cycle corner sequences.
module tb_mdu_ctrl;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, wr_en;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   mdu_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .wr_en (wr_en),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] v);
      wr_en = 1'b1; md_op = op; A = v;
      step();
      wr_en = 1'b0;
   endtask

   task automatic preload();
      mt(OP_MTHI, 32'h1111_1111);
      mt(OP_MTLO, 32'h2222_2222);
   endtask

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic we);
      start = 1'b1; wr_en = we; md_op = op; A = a; B = b;
      step();
      start = 1'b0; wr_en = 1'b0;
   endtask

   // Counts edges until busy drops, scrambling operands meanwhile.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         A = $urandom; B = $urandom;
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      reset = 1'b1; start = 1'b0; wr_en = 1'b0; md_op = 3'd0; A = '0; B = '0;

      vecs[0]  = '{1'b1, OP_MULT,  32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1]  = '{1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2]  = '{1'b1, OP_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{1'b1, OP_DIVU,  32'd7,         32'd0,        10, 32'h1111_1111, 32'h2222_2222};
      vecs[4]  = '{1'b1, OP_DIVU,  32'd100,       32'd7,        10, 32'h0000_0002, 32'h0000_000E};
      vecs[5]  = '{1'b1, OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6]  = '{1'b1, OP_MULT,  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000};
      vecs[7]  = '{1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[8]  = '{1'b1, OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001};
      vecs[9]  = '{1'b1, OP_DIV,   32'hFFFF_FFF9, 32'd0,        10, 32'h1111_1111, 32'h2222_2222};
      vecs[10] = '{1'b0, OP_MTLO,  32'h1234_5678, 32'd0,        0,  32'h1111_1111, 32'h1234_5678};
      vecs[11] = '{1'b0, OP_MTHI,  32'hABCD_EF01, 32'd0,        0,  32'hABCD_EF01, 32'h2222_2222};

      step(); step();
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_hi", {32'd0, HI}, 64'd0);
      chk("reset_lo", {32'd0, LO}, 64'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 12; i++) begin
         preload();
         if (vecs[i].st) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            chk($sformatf("v%0d_busy_rise", i), {63'd0, busy}, 64'd1);
            wait_idle(n);
            chk($sformatf("v%0d_lat", i), 64'(n), 64'(vecs[i].lat));
         end else begin
            mt(vecs[i].op, vecs[i].a);
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd0);
         end
         chk($sformatf("v%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].hi});
         chk($sformatf("v%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].lo});
      end

      // non-mult/div start is ignored
      preload();
      launch(3'd6, 32'd9, 32'd9, 1'b0);
      chk("badop_busy", {63'd0, busy}, 64'd0);
      chk("badop_hi", {32'd0, HI}, 64'h1111_1111);

      // operands change during run, second start at cycle 2 ignored
      preload();
      launch(OP_MULT, 32'd5, 32'd7, 1'b0);
      start = 1'b1; md_op = OP_DIV; A = $urandom; B = $urandom;
      step();
      start = 1'b0;
      wait_idle(n);
      chk("restart_lat", 64'(n + 1), 64'd5);
      chk("restart_hi", {32'd0, HI}, 64'd0);
      chk("restart_lo", {32'd0, LO}, 64'd35);
      step();
      chk("restart_idle", {63'd0, busy}, 64'd0);

      // MTHI/MTLO during a DIV run are dropped
      preload();
      launch(OP_DIVU, 32'd100, 32'd7, 1'b0);
      step(); step();
      mt(OP_MTHI, 32'hFFFF_0000);
      chk("midrun_hi", {32'd0, HI}, 64'h1111_1111);
      mt(OP_MTLO, 32'hFFFF_0000);
      chk("midrun_lo", {32'd0, LO}, 64'h2222_2222);
      wait_idle(n);
      chk("midrun_lat", 64'(n + 4), 64'd10);
      chk("midrun_res_hi", {32'd0, HI}, 64'd2);
      chk("midrun_res_lo", {32'd0, LO}, 64'd14);

      // start and wr_en together: start wins, no write at the start edge
      preload();
      launch(OP_MULT, 32'd3, 32'd4, 1'b1);
      chk("both_busy", {63'd0, busy}, 64'd1);
      chk("both_hi", {32'd0, HI}, 64'h1111_1111);
      chk("both_lo", {32'd0, LO}, 64'h2222_2222);
      wait_idle(n);
      chk("both_res_lo", {32'd0, LO}, 64'd12);
      preload();
      launch(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
      chk("both_mthi_dropped", {32'd0, HI}, 64'h1111_1111);
      chk("both_mthi_busy", {63'd0, busy}, 64'd0);

      // asynchronous reset mid-DIV
      preload();
      launch(OP_DIV, 32'd50, 32'd3, 1'b0);
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_hi", {32'd0, HI}, 64'd0);
      chk("rst_lo", {32'd0, LO}, 64'd0);
      step();
      reset = 1'b0;
      repeat (15) step();
      chk("rst_later_busy", {63'd0, busy}, 64'd0);
      chk("rst_later_hi", {32'd0, HI}, 64'd0);
      chk("rst_later_lo", {32'd0, LO}, 64'd0);
      launch(OP_MULTU, 32'd6, 32'd7, 1'b0);
      chk("post_rst_busy", {63'd0, busy}, 64'd1);
      wait_idle(n);
      chk("post_rst_lat", 64'(n), 64'd5);
      chk("post_rst_hi", {32'd0, HI}, 64'd0);
      chk("post_rst_lo", {32'd0, LO}, 64'd42);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
